// File: rtl/decode_stage_if.sv
// Handshake bundle between fetch, decode and execute.
// The decode stage is the slave; the fetch/execute side (or a bench) is the master.
interface decode_stage_if #(
  parameter int unsigned XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [XLEN-1:0] out_imm;
  logic [10:0]     out_alu_op;
  logic [3:0]      out_instr_type;
  logic            out_reg_write;
  logic            out_mem_read;
  logic            out_mem_write;
  logic [1:0]      out_mem_size;
  logic            out_mem_unsigned;
  logic            out_branch;
  logic            out_jump;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_imm, out_alu_op,
           out_instr_type, out_reg_write, out_mem_read, out_mem_write, out_mem_size,
           out_mem_unsigned, out_branch, out_jump, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_imm, out_alu_op,
           out_instr_type, out_reg_write, out_mem_read, out_mem_write, out_mem_size,
           out_mem_unsigned, out_branch, out_jump, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32/RV64 I+M decode stage: combinational decode of the accepted word into a
// small output FIFO, with flush, consumed-entry counter and illegal detection.
module decode_stage #(
  parameter int unsigned XLEN     = 64,
  parameter bit          ENABLE_M = 1'b1,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  decode_stage_if.slave    bus,
  output logic [CNT_W-1:0] decode_count
);
  localparam logic [10:0] AluNothing = 11'd0,  AluAdd  = 11'd1,  AluSub   = 11'd2;
  localparam logic [10:0] AluSll     = 11'd3,  AluSlt  = 11'd4,  AluSltu  = 11'd5;
  localparam logic [10:0] AluXor     = 11'd6,  AluSrl  = 11'd7,  AluSra   = 11'd8;
  localparam logic [10:0] AluOr      = 11'd9,  AluAnd  = 11'd10, AluMul   = 11'd11;
  localparam logic [10:0] AluBeq     = 11'd19, AluBne  = 11'd20, AluBlt   = 11'd21;
  localparam logic [10:0] AluBge     = 11'd22, AluBltu = 11'd23, AluBgeu  = 11'd24;
  localparam logic [10:0] AluAddw    = 11'd25, AluSubw = 11'd26, AluSllw  = 11'd27;
  localparam logic [10:0] AluSrlw    = 11'd28, AluSraw = 11'd29, AluMulw  = 11'd30;
  localparam logic [10:0] AluDivw    = 11'd31, AluDivuw = 11'd32, AluRemw = 11'd33;
  localparam logic [10:0] AluRemuw   = 11'd34;

  localparam logic [3:0] TypeNone = 4'd0, TypeR = 4'd1, TypeI = 4'd2, TypeS = 4'd3;
  localparam logic [3:0] TypeSb   = 4'd4, TypeU = 4'd5, TypeUj = 4'd6;

  localparam bit          Rv64 = (XLEN == 64);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OccW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [10:0]     alu_op;
    logic [3:0]      instr_type;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic [1:0]      mem_size;
    logic            mem_unsigned;
    logic            branch;
    logic            jump;
    logic            illegal;
  } entry_t;

  function automatic logic [10:0] base_op(input logic [2:0] f);
    case (f)
      3'd0:    base_op = AluAdd;
      3'd1:    base_op = AluSll;
      3'd2:    base_op = AluSlt;
      3'd3:    base_op = AluSltu;
      3'd4:    base_op = AluXor;
      3'd5:    base_op = AluSrl;
      3'd6:    base_op = AluOr;
      default: base_op = AluAnd;
    endcase
  endfunction

  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic            bad;
  logic            writes;
  entry_t          dec;

  assign instr  = bus.in_instr;
  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign imm_i  = XLEN'($signed(instr[31:20]));
  assign imm_s  = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_b  = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_u  = XLEN'($signed({instr[31:12], 12'b0}));
  assign imm_j  = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));

  always_comb begin
    dec            = '0;
    bad            = 1'b0;
    writes         = 1'b0;
    dec.pc         = bus.in_pc;
    dec.rd         = instr[11:7];
    dec.rs1        = instr[19:15];
    dec.rs2        = instr[24:20];
    dec.instr_type = TypeNone;
    dec.alu_op     = AluNothing;
    case (opcode)
      7'b0110111, 7'b0010111: begin
        dec.instr_type = TypeU; dec.alu_op = AluAdd; dec.imm = imm_u; writes = 1'b1;
        dec.rs1 = '0; dec.rs2 = '0;
      end
      7'b1101111: begin
        dec.instr_type = TypeUj; dec.alu_op = AluAdd; dec.imm = imm_j; writes = 1'b1;
        dec.jump = 1'b1; dec.rs1 = '0; dec.rs2 = '0;
      end
      7'b1100111: begin
        dec.instr_type = TypeI; dec.alu_op = AluAdd; dec.imm = imm_i; writes = 1'b1;
        dec.jump = 1'b1; dec.rs2 = '0; bad = (f3 != 3'd0);
      end
      7'b1100011: begin
        dec.instr_type = TypeSb; dec.imm = imm_b; dec.branch = 1'b1; dec.rd = '0;
        case (f3)
          3'd0:    dec.alu_op = AluBeq;
          3'd1:    dec.alu_op = AluBne;
          3'd4:    dec.alu_op = AluBlt;
          3'd5:    dec.alu_op = AluBge;
          3'd6:    dec.alu_op = AluBltu;
          3'd7:    dec.alu_op = AluBgeu;
          default: bad = 1'b1;
        endcase
      end
      7'b0000011: begin
        dec.instr_type = TypeI; dec.alu_op = AluAdd; dec.imm = imm_i; writes = 1'b1;
        dec.mem_read = 1'b1; dec.mem_size = f3[1:0]; dec.mem_unsigned = f3[2]; dec.rs2 = '0;
        bad = (f3 == 3'd7) || (!Rv64 && (f3 == 3'd3 || f3 == 3'd6));
      end
      7'b0100011: begin
        dec.instr_type = TypeS; dec.alu_op = AluAdd; dec.imm = imm_s; dec.rd = '0;
        dec.mem_write = 1'b1; dec.mem_size = f3[1:0];
        bad = f3[2] || (!Rv64 && f3 == 3'd3);
      end
      7'b0010011: begin
        dec.instr_type = TypeI; dec.alu_op = base_op(f3); dec.imm = imm_i; writes = 1'b1;
        dec.rs2 = '0;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          // Shift-immediates carry the raw shamt; bit 30 selects arithmetic right shift.
          dec.imm = XLEN'(instr[25:20]);
          if (f3 == 3'd5 && instr[30]) dec.alu_op = AluSra;
          bad = instr[31] || (instr[29:26] != 4'd0) || (instr[30] && f3 == 3'd1) ||
                (!Rv64 && instr[25]);
        end
        if (instr == 32'h0000_0013) dec.alu_op = AluNothing;
      end
      7'b0011011: begin
        dec.instr_type = TypeI; dec.imm = imm_i; writes = 1'b1; dec.rs2 = '0; bad = !Rv64;
        case (f3)
          3'd0: dec.alu_op = AluAddw;
          3'd1: begin
            dec.alu_op = AluSllw; dec.imm = XLEN'(instr[24:20]);
            if (f7 != 7'd0) bad = 1'b1;
          end
          3'd5: begin
            dec.alu_op = instr[30] ? AluSraw : AluSrlw; dec.imm = XLEN'(instr[24:20]);
            if (f7 != 7'd0 && f7 != 7'b0100000) bad = 1'b1;
          end
          default: bad = 1'b1;
        endcase
      end
      7'b0110011: begin
        dec.instr_type = TypeR; writes = 1'b1;
        case (f7)
          7'b0000000: dec.alu_op = base_op(f3);
          7'b0100000: begin
            if (f3 == 3'd0)      dec.alu_op = AluSub;
            else if (f3 == 3'd5) dec.alu_op = AluSra;
            else                 bad = 1'b1;
          end
          7'b0000001: begin
            dec.alu_op = AluMul + {8'd0, f3};
            bad = !ENABLE_M;
          end
          default: bad = 1'b1;
        endcase
      end
      7'b0111011: begin
        dec.instr_type = TypeR; writes = 1'b1; bad = !Rv64;
        case (f7)
          7'b0000000: begin
            if (f3 == 3'd0)      dec.alu_op = AluAddw;
            else if (f3 == 3'd1) dec.alu_op = AluSllw;
            else if (f3 == 3'd5) dec.alu_op = AluSrlw;
            else                 bad = 1'b1;
          end
          7'b0100000: begin
            if (f3 == 3'd0)      dec.alu_op = AluSubw;
            else if (f3 == 3'd5) dec.alu_op = AluSraw;
            else                 bad = 1'b1;
          end
          7'b0000001: begin
            if (!ENABLE_M) bad = 1'b1;
            case (f3)
              3'd0:    dec.alu_op = AluMulw;
              3'd4:    dec.alu_op = AluDivw;
              3'd5:    dec.alu_op = AluDivuw;
              3'd6:    dec.alu_op = AluRemw;
              3'd7:    dec.alu_op = AluRemuw;
              default: bad = 1'b1;
            endcase
          end
          default: bad = 1'b1;
        endcase
      end
      7'b0001111: begin
        dec.rd = '0; dec.rs1 = '0; dec.rs2 = '0; bad = (f3 != 3'd0);
      end
      7'b1110011: begin
        dec.rd = '0; dec.rs1 = '0; dec.rs2 = '0;
        bad = !(instr == 32'h0000_0073 || instr == 32'h0010_0073);
      end
      default: bad = 1'b1;
    endcase
    dec.reg_write = writes && (dec.rd != 5'd0);
    if (bad || instr[1:0] != 2'b11) begin
      dec            = '0;
      dec.pc         = bus.in_pc;
      dec.illegal    = 1'b1;
      dec.instr_type = TypeNone;
      dec.alu_op     = AluNothing;
    end
  end

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    next_ptr = (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  entry_t           mem_q [DEPTH];
  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [OccW-1:0]  occ_q;
  logic [CNT_W-1:0] count_q;
  logic             push, pop;
  entry_t           head;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      count_q  <= '0;
    end else begin
      // A pop in the flush cycle was seen by the consumer, so it still counts.
      if (pop) count_q <= count_q + 1'b1;
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        occ_q    <= '0;
      end else begin
        if (push) begin
          mem_q[wr_ptr_q] <= dec;
          wr_ptr_q        <= next_ptr(wr_ptr_q);
        end
        if (pop) rd_ptr_q <= next_ptr(rd_ptr_q);
        if (push && !pop)      occ_q <= occ_q + 1'b1;
        else if (pop && !push) occ_q <= occ_q - 1'b1;
      end
    end
  end

  assign head                 = (occ_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign bus.in_ready         = (occ_q < OccW'(DEPTH));
  assign bus.out_valid        = (occ_q != '0);
  assign bus.out_pc           = head.pc;
  assign bus.out_rd           = head.rd;
  assign bus.out_rs1          = head.rs1;
  assign bus.out_rs2          = head.rs2;
  assign bus.out_imm          = head.imm;
  assign bus.out_alu_op       = head.alu_op;
  assign bus.out_instr_type   = head.instr_type;
  assign bus.out_reg_write    = head.reg_write;
  assign bus.out_mem_read     = head.mem_read;
  assign bus.out_mem_write    = head.mem_write;
  assign bus.out_mem_size     = head.mem_size;
  assign bus.out_mem_unsigned = head.mem_unsigned;
  assign bus.out_branch       = head.branch;
  assign bus.out_jump         = head.jump;
  assign bus.out_illegal      = head.illegal;
  assign decode_count         = count_q;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: an RV64+M instance and an RV32 instance without M.
module tb_decode_stage;
  localparam logic [10:0] ANOTH = 11'd0, AADD = 11'd1, ASRA = 11'd8, AAND = 11'd10;
  localparam logic [10:0] AMUL = 11'd11, ABNE = 11'd20, AADDW = 11'd25, ASLL = 11'd3;
  localparam logic [3:0]  TNONE = 4'd0, TR = 4'd1, TI = 4'd2, TS = 4'd3, TSB = 4'd4;
  localparam logic [3:0]  TU = 4'd5, TUJ = 4'd6;

  typedef struct {
    logic [31:0] ins;
    logic        ill;
    logic [10:0] alu;
    logic [3:0]  typ;
    logic        rw;
    logic [63:0] imm;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        flush32 = 1'b0;
  logic [31:0] cnt64, cnt32, exp_cnt;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(64)) b64 ();
  decode_stage_if #(.XLEN(32)) b32 ();

  decode_stage #(.XLEN(64), .ENABLE_M(1'b1), .DEPTH(2), .CNT_W(32)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .bus(b64), .decode_count(cnt64)
  );
  decode_stage #(.XLEN(32), .ENABLE_M(1'b0), .DEPTH(2), .CNT_W(32)) dut32 (
    .clk(clk), .reset(reset), .flush(flush32), .bus(b32), .decode_count(cnt32)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] pc);
    b64.in_valid = v;
    b64.in_instr = ins;
    b64.in_pc    = pc;
  endtask

  task automatic test_reset;
    reset = 1'b0; flush = 1'b0; b64.out_ready = 1'b0;
    b32.in_valid = 1'b0; b32.in_instr = '0; b32.in_pc = '0; b32.out_ready = 1'b0;
    drive(1'b1, 32'h0000_0013, 64'h10);
    step; step;
    tests++; if (b64.out_valid !== 1'b0) begin fails++;
      $display("FAIL reset_out_valid: got %0h expected 0", b64.out_valid); end
    tests++; if (b64.in_ready !== 1'b1) begin fails++;
      $display("FAIL reset_in_ready: got %0h expected 1", b64.in_ready); end
    tests++; if (cnt64 !== 32'd0) begin fails++;
      $display("FAIL reset_count: got %0h expected 0", cnt64); end
    tests++; if (b64.out_pc !== 64'd0 || b64.out_alu_op !== ANOTH || b64.out_imm !== 64'd0) begin
      fails++; $display("FAIL reset_fields_zero: got pc=%0h alu=%0h imm=%0h expected 0",
                        b64.out_pc, b64.out_alu_op, b64.out_imm); end
    tests++; if (b32.out_valid !== 1'b0) begin fails++;
      $display("FAIL reset_out_valid32: got %0h expected 0", b32.out_valid); end
    reset = 1'b1;
    drive(1'b1, 32'hFFF0_0293, 64'h100);
    step;
    tests++; if (b64.out_valid !== 1'b1) begin fails++;
      $display("FAIL first_accept_valid: got %0h expected 1", b64.out_valid); end
    tests++; if (b64.out_pc !== 64'h100) begin fails++;
      $display("FAIL first_accept_pc: got %0h expected 100", b64.out_pc); end
    drive(1'b0, 32'h0, 64'h0); b64.out_ready = 1'b1;
    step;
    exp_cnt = 32'd1;
    tests++; if (b64.out_valid !== 1'b0) begin fails++;
      $display("FAIL first_pop_valid: got %0h expected 0", b64.out_valid); end
    tests++; if (cnt64 !== exp_cnt) begin fails++;
      $display("FAIL first_pop_count: got %0h expected %0h", cnt64, exp_cnt); end
    b64.out_ready = 1'b0;
  endtask

  task automatic test_stream;
    b64.out_ready = 1'b1;
    drive(1'b1, 32'hFFF0_0293, 64'h1000);
    step;
    tests++; if (b64.out_imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin fails++;
      $display("FAIL addi_imm: got %0h expected ffffffffffffffff", b64.out_imm); end
    tests++; if (b64.out_alu_op !== AADD || b64.out_reg_write !== 1'b1) begin fails++;
      $display("FAIL addi_op_rw: got %0h/%0h expected %0h/1", b64.out_alu_op,
               b64.out_reg_write, AADD); end
    tests++; if (b64.out_rd !== 5'd5 || b64.out_instr_type !== TI) begin fails++;
      $display("FAIL addi_rd_type: got %0h/%0h expected 5/%0h", b64.out_rd,
               b64.out_instr_type, TI); end
    drive(1'b1, 32'h0082_B303, 64'h1004);
    step;
    tests++; if (b64.out_pc !== 64'h1004 || b64.out_mem_read !== 1'b1) begin fails++;
      $display("FAIL ld_pc_mr: got %0h/%0h expected 1004/1", b64.out_pc, b64.out_mem_read); end
    tests++; if (b64.out_mem_size !== 2'd3 || b64.out_imm !== 64'd8) begin fails++;
      $display("FAIL ld_size_imm: got %0h/%0h expected 3/8", b64.out_mem_size, b64.out_imm); end
    tests++; if (b64.out_rd !== 5'd6 || b64.out_rs1 !== 5'd5 || b64.out_alu_op !== AADD) begin
      fails++; $display("FAIL ld_regs: got rd=%0h rs1=%0h alu=%0h expected 6/5/%0h",
                        b64.out_rd, b64.out_rs1, b64.out_alu_op, AADD); end
    tests++; if (b64.out_mem_unsigned !== 1'b0 || b64.out_mem_write !== 1'b0) begin fails++;
      $display("FAIL ld_flags: got %0h/%0h expected 0/0", b64.out_mem_unsigned,
               b64.out_mem_write); end
    drive(1'b0, 32'h0, 64'h0);
    step;
    exp_cnt += 32'd2;
    tests++; if (cnt64 !== exp_cnt) begin fails++;
      $display("FAIL stream_count: got %0h expected %0h", cnt64, exp_cnt); end
    b64.out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    b64.out_ready = 1'b0;
    drive(1'b1, 32'h0010_0093, 64'h2000); step;
    drive(1'b1, 32'h0020_0113, 64'h2004); step;
    tests++; if (b64.in_ready !== 1'b0) begin fails++;
      $display("FAIL bp_full_ready: got %0h expected 0", b64.in_ready); end
    drive(1'b1, 32'h0030_0193, 64'h2008); step;
    tests++; if (b64.in_ready !== 1'b0 || b64.out_pc !== 64'h2000) begin fails++;
      $display("FAIL bp_held: got ready=%0h pc=%0h expected 0/2000", b64.in_ready, b64.out_pc); end
    b64.out_ready = 1'b1;
    step;
    tests++; if (b64.out_pc !== 64'h2004 || b64.out_imm !== 64'd2) begin fails++;
      $display("FAIL bp_second: got pc=%0h imm=%0h expected 2004/2", b64.out_pc, b64.out_imm); end
    tests++; if (b64.in_ready !== 1'b1) begin fails++;
      $display("FAIL bp_ready_again: got %0h expected 1", b64.in_ready); end
    step;
    drive(1'b0, 32'h0, 64'h0);
    tests++; if (b64.out_pc !== 64'h2008 || b64.out_rd !== 5'd3) begin fails++;
      $display("FAIL bp_third: got pc=%0h rd=%0h expected 2008/3", b64.out_pc, b64.out_rd); end
    step;
    exp_cnt += 32'd3;
    tests++; if (b64.out_valid !== 1'b0 || cnt64 !== exp_cnt) begin fails++;
      $display("FAIL bp_drained: got valid=%0h cnt=%0h expected 0/%0h", b64.out_valid,
               cnt64, exp_cnt); end
    b64.out_ready = 1'b0;
  endtask

  task automatic test_decode64;
    vec_t v [12];
    v[0]  = '{32'h0253_03B3, 1'b0, AMUL,  TR,    1'b1, 64'd0};
    v[1]  = '{32'h0053_03BB, 1'b0, AADDW, TR,    1'b1, 64'd0};
    v[2]  = '{32'h0000_0010, 1'b1, ANOTH, TNONE, 1'b0, 64'd0};
    v[3]  = '{32'h0062_C023, 1'b1, ANOTH, TNONE, 1'b0, 64'd0};
    v[4]  = '{32'h0062_B023, 1'b0, AADD,  TS,    1'b0, 64'd0};
    v[5]  = '{32'h4053_5393, 1'b0, ASRA,  TI,    1'b1, 64'd5};
    v[6]  = '{32'h0000_006F, 1'b0, AADD,  TUJ,   1'b0, 64'd0};
    v[7]  = '{32'h0000_7013, 1'b0, AAND,  TI,    1'b0, 64'd0};
    v[8]  = '{32'h0453_03B3, 1'b1, ANOTH, TNONE, 1'b0, 64'd0};
    v[9]  = '{32'h0002_F303, 1'b1, ANOTH, TNONE, 1'b0, 64'd0};
    v[10] = '{32'h8000_02B7, 1'b0, AADD,  TU,    1'b1, 64'hFFFF_FFFF_8000_0000};
    v[11] = '{32'hFE62_9EE3, 1'b0, ABNE,  TSB,   1'b0, 64'hFFFF_FFFF_FFFF_FFFC};
    b64.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, v[i].ins, 64'h6000 + 64'(4 * i));
      step;
      tests++; if (b64.out_valid !== 1'b1 || b64.out_pc !== 64'h6000 + 64'(4 * i)) begin
        fails++; $display("FAIL d64[%0d] pc: got %0h expected %0h", i, b64.out_pc,
                          64'h6000 + 64'(4 * i)); end
      tests++; if (b64.out_illegal !== v[i].ill) begin fails++;
        $display("FAIL d64[%0d] illegal: got %0h expected %0h", i, b64.out_illegal, v[i].ill); end
      tests++; if (b64.out_alu_op !== v[i].alu) begin fails++;
        $display("FAIL d64[%0d] alu: got %0h expected %0h", i, b64.out_alu_op, v[i].alu); end
      tests++; if (b64.out_instr_type !== v[i].typ) begin fails++;
        $display("FAIL d64[%0d] type: got %0h expected %0h", i, b64.out_instr_type, v[i].typ); end
      tests++; if (b64.out_reg_write !== v[i].rw) begin fails++;
        $display("FAIL d64[%0d] rw: got %0h expected %0h", i, b64.out_reg_write, v[i].rw); end
      tests++; if (b64.out_imm !== v[i].imm) begin fails++;
        $display("FAIL d64[%0d] imm: got %0h expected %0h", i, b64.out_imm, v[i].imm); end
      if (i == 6) begin
        tests++; if (b64.out_jump !== 1'b1) begin fails++;
          $display("FAIL d64 jal jump: got %0h expected 1", b64.out_jump); end
      end
      if (i == 11) begin
        tests++; if (b64.out_branch !== 1'b1) begin fails++;
          $display("FAIL d64 bne branch: got %0h expected 1", b64.out_branch); end
      end
    end
    drive(1'b0, 32'h0, 64'h0);
    step;
    exp_cnt += 32'd12;
    tests++; if (cnt64 !== exp_cnt) begin fails++;
      $display("FAIL d64 count: got %0h expected %0h", cnt64, exp_cnt); end
    b64.out_ready = 1'b0;
  endtask

  task automatic test_decode32;
    vec_t v [8];
    v[0] = '{32'h0053_03BB, 1'b1, ANOTH, TNONE, 1'b0, 64'd0};
    v[1] = '{32'h0253_03B3, 1'b1, ANOTH, TNONE, 1'b0, 64'd0};
    v[2] = '{32'h0082_B303, 1'b1, ANOTH, TNONE, 1'b0, 64'd0};
    v[3] = '{32'h0202_9293, 1'b1, ANOTH, TNONE, 1'b0, 64'd0};
    v[4] = '{32'h0053_03B3, 1'b0, AADD,  TR,    1'b1, 64'd0};
    v[5] = '{32'hFFF0_0293, 1'b0, AADD,  TI,    1'b1, 64'hFFFF_FFFF};
    v[6] = '{32'h01F2_9293, 1'b0, ASLL,  TI,    1'b1, 64'd31};
    v[7] = '{32'h0082_A303, 1'b0, AADD,  TI,    1'b1, 64'd8};
    b32.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b32.in_valid = 1'b1; b32.in_instr = v[i].ins; b32.in_pc = 32'h300 + 32'(4 * i);
      step;
      tests++; if (b32.out_valid !== 1'b1 || b32.out_pc !== 32'h300 + 32'(4 * i)) begin
        fails++; $display("FAIL d32[%0d] pc: got %0h expected %0h", i, b32.out_pc,
                          32'h300 + 32'(4 * i)); end
      tests++; if (b32.out_illegal !== v[i].ill) begin fails++;
        $display("FAIL d32[%0d] illegal: got %0h expected %0h", i, b32.out_illegal, v[i].ill); end
      tests++; if (b32.out_alu_op !== v[i].alu) begin fails++;
        $display("FAIL d32[%0d] alu: got %0h expected %0h", i, b32.out_alu_op, v[i].alu); end
      tests++; if (b32.out_instr_type !== v[i].typ) begin fails++;
        $display("FAIL d32[%0d] type: got %0h expected %0h", i, b32.out_instr_type, v[i].typ); end
      tests++; if (b32.out_reg_write !== v[i].rw) begin fails++;
        $display("FAIL d32[%0d] rw: got %0h expected %0h", i, b32.out_reg_write, v[i].rw); end
      tests++; if (b32.out_imm !== v[i].imm[31:0]) begin fails++;
        $display("FAIL d32[%0d] imm: got %0h expected %0h", i, b32.out_imm, v[i].imm[31:0]); end
    end
    b32.in_valid = 1'b0;
    step;
    tests++; if (cnt32 !== 32'd8 || b32.out_valid !== 1'b0) begin fails++;
      $display("FAIL d32 drain: got cnt=%0h valid=%0h expected 8/0", cnt32, b32.out_valid); end
    b32.out_ready = 1'b0;
  endtask

  task automatic test_flush;
    b64.out_ready = 1'b0;
    drive(1'b1, 32'h0010_0093, 64'h4000); step;
    drive(1'b1, 32'h0020_0113, 64'h4004); step;
    tests++; if (b64.in_ready !== 1'b0) begin fails++;
      $display("FAIL flush_full_ready: got %0h expected 0", b64.in_ready); end
    drive(1'b1, 32'h0030_0193, 64'h4008); flush = 1'b1;
    step;
    flush = 1'b0; drive(1'b0, 32'h0, 64'h0);
    tests++; if (b64.out_valid !== 1'b0 || b64.in_ready !== 1'b1) begin fails++;
      $display("FAIL flush_full: got valid=%0h ready=%0h expected 0/1", b64.out_valid,
               b64.in_ready); end
    tests++; if (b64.out_pc !== 64'd0 || cnt64 !== exp_cnt) begin fails++;
      $display("FAIL flush_full_state: got pc=%0h cnt=%0h expected 0/%0h", b64.out_pc,
               cnt64, exp_cnt); end
    drive(1'b1, 32'h0040_0213, 64'h4010); step;
    drive(1'b1, 32'h0050_0293, 64'h4014); flush = 1'b1;
    step;
    flush = 1'b0; drive(1'b0, 32'h0, 64'h0);
    tests++; if (b64.out_valid !== 1'b0) begin fails++;
      $display("FAIL flush_same_cycle: got %0h expected 0", b64.out_valid); end
    step;
    tests++; if (b64.out_valid !== 1'b0) begin fails++;
      $display("FAIL flush_no_ghost: got %0h expected 0", b64.out_valid); end
    drive(1'b1, 32'h0060_0313, 64'h4020); step;
    drive(1'b0, 32'h0, 64'h0);
    tests++; if (b64.out_pc !== 64'h4020 || b64.out_imm !== 64'd6) begin fails++;
      $display("FAIL flush_next_entry: got pc=%0h imm=%0h expected 4020/6", b64.out_pc,
               b64.out_imm); end
    b64.out_ready = 1'b1; flush = 1'b1;
    step;
    flush = 1'b0; b64.out_ready = 1'b0;
    exp_cnt += 32'd1;
    tests++; if (b64.out_valid !== 1'b0 || cnt64 !== exp_cnt) begin fails++;
      $display("FAIL flush_pop_counts: got valid=%0h cnt=%0h expected 0/%0h", b64.out_valid,
               cnt64, exp_cnt); end
  endtask

  task automatic test_back_to_back;
    b64.out_ready = 1'b1;
    drive(1'b1, 32'h0000_0013, 64'h5000); step;
    drive(1'b1, 32'h0000_0013, 64'h5004);
    tests++; if (b64.out_pc !== 64'h5000 || b64.out_alu_op !== ANOTH) begin fails++;
      $display("FAIL nop1: got pc=%0h alu=%0h expected 5000/%0h", b64.out_pc,
               b64.out_alu_op, ANOTH); end
    tests++; if (b64.out_reg_write !== 1'b0 || b64.out_illegal !== 1'b0) begin fails++;
      $display("FAIL nop1_flags: got rw=%0h ill=%0h expected 0/0", b64.out_reg_write,
               b64.out_illegal); end
    step;
    drive(1'b0, 32'h0, 64'h0);
    tests++; if (b64.out_valid !== 1'b1 || b64.out_pc !== 64'h5004) begin fails++;
      $display("FAIL nop2: got valid=%0h pc=%0h expected 1/5004", b64.out_valid, b64.out_pc); end
    tests++; if (b64.out_alu_op !== ANOTH || b64.out_reg_write !== 1'b0 ||
                 b64.out_illegal !== 1'b0) begin fails++;
      $display("FAIL nop2_flags: got alu=%0h rw=%0h ill=%0h expected 0/0/0", b64.out_alu_op,
               b64.out_reg_write, b64.out_illegal); end
    step;
    exp_cnt += 32'd2;
    tests++; if (b64.out_valid !== 1'b0 || cnt64 !== exp_cnt) begin fails++;
      $display("FAIL nop_count: got valid=%0h cnt=%0h expected 0/%0h", b64.out_valid,
               cnt64, exp_cnt); end
    b64.out_ready = 1'b0;
  endtask

  initial begin
    test_reset;
    test_stream;
    test_backpressure;
    test_decode64;
    test_decode32;
    test_flush;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipelined RV32/RV64 (I+M) instruction decode stage with valid/ready handshakes on both sides.
- Sits between fetch and the register-read/ALU stage. Each accepted instruction is decoded exactly once into a registered control bundle.
- Results are held in a DEPTH-entry output FIFO, so back-pressure from execute never drops or duplicates an instruction.
- Adds a flush, a decoded-instruction counter and illegal-instruction detection.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64. Sets the width of pc and imm.
- ENABLE_M, 1, when 0 the M-extension encodings decode as illegal.
- DEPTH, 2, output FIFO entries; legal range 1..4.
- CNT_W, 32, width of decode_count.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset.
- flush  in  1  discard all buffered entries.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept an instruction.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  head FIFO entry valid.
- out_ready  in  1  consumer accepts the head entry.
- out_pc  out  XLEN  pc of the head entry.
- out_rd, out_rs1, out_rs2  out  5 each  register specifiers.
- out_imm  out  XLEN  sign-extended immediate (I/S/SB/U/UJ), or zero-extended shamt for shift-immediate ops.
- out_alu_op  out  11  ALU operation code from the Alu.defs macros; `NOTHING when there is no ALU work.
- out_instr_type  out  4  `RTYPE/`ITYPE/`STYPE/`SBTYPE/`UTYPE/`UJTYPE/`NOTYPE.
- out_reg_write  out  1  writes rd.
- out_mem_read, out_mem_write  out  1 each  load / store.
- out_mem_size  out  2  0=B, 1=H, 2=W, 3=D.
- out_mem_unsigned  out  1  LBU/LHU/LWU.
- out_branch, out_jump  out  1 each  SB-type / JAL or JALR.
- out_illegal  out  1  entry is an illegal encoding.
- decode_count  out  CNT_W  count of entries consumed.

Behaviour:
- Reset (reset==0 at posedge): FIFO emptied, decode_count=0. Afterwards out_valid=0 and in_ready=1. All out_* data fields read 0 while the FIFO is empty.
- Accept condition: in_valid && in_ready. Decode is combinational on in_instr and is written into the FIFO tail on the same edge.
- Latency: an instruction accepted at edge N has out_valid=1 after edge N; minimum one cycle.
- in_ready = (occupancy < DEPTH). It does not depend on out_ready in the same cycle, so there is no combinational in/out path.
- Pop condition: out_valid && out_ready. A simultaneous push and pop when full is not possible, because in_ready=0. When not full, a simultaneous push and pop leaves occupancy unchanged.
- Ordering: strict FIFO; entries are never reordered or dropped, except by flush.
- out_* fields always come from the head entry and stay stable while out_valid && !out_ready.
- flush=1 at an edge: occupancy becomes 0. An input accepted in the same cycle is discarded. A pop in the same cycle still counts in decode_count. reset has priority over flush.
- decode_count increments by 1 on each pop and wraps modulo 2^CNT_W.
- Decode rules:
  - rd==0 forces reg_write=0.
  - JAL/JALR: jump=1, reg_write=1 unless rd==0.
  - Loads: mem_read=1, alu_op=`ADD (address).
  - Stores: mem_write=1, alu_op=`ADD, reg_write=0.
  - NOP (addi x0,x0,0): alu_op=`NOTHING, reg_write=0, illegal=0.
- Illegal, when any of the following holds:
  - Unknown opcode.
  - Undefined func3/func7 combination.
  - Store with func3>3, or load with func3==7.
  - XLEN==32 and any W-form opcode, LD/SD/LWU, or shamt[5]==1.
  - ENABLE_M==0 and func7==0000001 in an R-type opcode.
  - in_instr[1:0]!=11.
- An illegal entry is still enqueued and emitted with illegal=1, alu_op=`NOTHING, instr_type=`NOTYPE, reg_write=mem_read=mem_write=branch=jump=0, and pc preserved.
- Identical consecutive instruction words are decoded independently (no duplicate suppression).

Test Plan:
- Reset with in_valid=1 → out_valid=0, in_ready=1, decode_count=0. The first accept after reset deasserts produces out_valid one cycle later.
- Stream addi x5,x0,-1 (0xFFF00293), then ld x6,8(x5) (0x0082B303), with out_ready=1:
  - addi entry: imm=0xFFFF_FFFF_FFFF_FFFF, alu_op=`ADD, reg_write=1.
  - ld entry: mem_read=1, mem_size=3, imm=8.
  - decode_count=2.
- out_ready=0, push 3 instructions, DEPTH=2 → in_ready drops after 2 accepts. The third is held by fetch. Releasing out_ready drains in order, with pc values matching.
- XLEN=32: addw (0x005303BB) → illegal=1, reg_write=0, instr_type=`NOTYPE. ENABLE_M=0: mul (0x025303B3) → illegal=1.
- Full FIFO plus flush with in_valid=1 in the same cycle → next cycle out_valid=0, in_ready=1. The flushed and same-cycle entries never appear on the output.
- Same word 0x00000013 presented twice back-to-back → two entries emitted, both alu_op=`NOTHING, reg_write=0, illegal=0. decode_count advances by 2.
